avalon_ibex_translator_pipelined: RTL
=====================================

Name: avalon_ibex_translator_pipelined

Overview:
- Parametrised successor to the single-outstanding data-side Avalon translators.
- Converts the ibex LSU req/gnt/rvalid protocol into an Avalon-MM pipelined master.
- Supports up to MaxOutstanding in-order reads, an optional Avalon write-response channel, configurable width and word/byte addressing.
- Sits between ibex_core data ports and the system interconnect inside the Avalon core wrapper.

Parameters:
- AddrWidth, 32, address width on both sides.
- DataWidth, 32, data width; must be a multiple of 8. BeWidth = DataWidth/8.
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (1..8).
- WordAddr, 1: avm_address = data_addr_i >> log2(BeWidth), upper bits zero-filled. 0: byte address passed unchanged.
- WriteResponse, 0: 1 = writes complete on avm_writeresponsevalid. 0 = writes complete internally.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  ibex request
- data_we_i  in  1  1 = write
- data_be_i  in  BeWidth  byte enables
- data_addr_i  in  AddrWidth  byte address
- data_wdata_i  in  DataWidth  write data
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  DataWidth  read data
- data_err_o  out  1  response error, qualified by data_rvalid_o
- avm_address  out  AddrWidth  Avalon address
- avm_byteenable  out  BeWidth  Avalon byteenable
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  DataWidth  Avalon write data
- avm_waitrequest  in  1  Avalon stall
- avm_readdatavalid  in  1  read data valid
- avm_readdata  in  DataWidth  read data
- avm_response  in  2  00 = OKAY, anything else = error
- avm_writeresponsevalid  in  1  write response valid; ignored when WriteResponse=0
- outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count
- protocol_err_o  out  1  sticky unexpected-response flag

Behaviour:
- Reset: every output register clears to 0. Tracking FIFO empty, count 0, protocol_err_o 0.
- Command path is combinational and passes through unregistered:
  - avm_read = data_req_i & ~data_we_i & ~blocked.
  - avm_write = data_req_i & data_we_i & ~blocked.
  - data_gnt_o = (avm_read | avm_write) & ~avm_waitrequest.
  - address, byteenable and writedata follow the inputs; ibex holds them stable until gnt.
- blocked = (count == MaxOutstanding), OR (data_we_i & WriteResponse==0 & (count != 0 | wr_pend)).
  - No same-cycle bypass: a completion in the same cycle does not unblock.
- Tracking FIFO: depth MaxOutstanding, 1 bit per entry (0 = read, 1 = write).
  - Push on every granted read, and on every granted write when WriteResponse=1.
- Completion fires when the head is a read and avm_readdatavalid, or the head is a write and avm_writeresponsevalid. Only one completion per cycle (Avalon never returns both in one cycle).
- Completion effects:
  - Pop the FIFO.
  - Next cycle: data_rvalid_o = 1, data_rdata_o = avm_readdata (reads) or 0 (writes), data_err_o = (avm_response != 0).
  - Response latency is exactly 1 cycle after readdatavalid / writeresponsevalid.
- WriteResponse=0:
  - A write is granted only when count == 0.
  - The grant sets wr_pend; data_rvalid_o = 1 with err = 0 on the next cycle, then wr_pend clears.
  - Writes never enter the FIFO or count.
- Count: +1 on push, −1 on pop, unchanged when both occur in one cycle. outstanding_o = count.
- protocol_err_o sets, and stays set until reset, on any of:
  - avm_readdatavalid with the FIFO empty or the head a write;
  - avm_writeresponsevalid (WriteResponse=1) with the FIFO empty or the head a read.
  - The stray response is dropped: no rvalid is generated.
- Mid-operation reset: all tracking is lost. Responses that arrive after reset release are treated as stray.
- data_rvalid_o is a single-cycle pulse per transaction, in command order.

Test Plan:
- Read, waitrequest low, readdatavalid 2 cycles after gnt with readdata=0xDEADBEEF, response 00 → rvalid 1 cycle later, rdata 0xDEADBEEF, err 0; avm_address = addr>>2 (addr 0x100 → 0x40).
- MaxOutstanding=2, three back-to-back reads, no responses → gnt for first two only, outstanding_o=2, third gnt withheld. One readdatavalid → third granted the following cycle; three rvalids in order.
- WriteResponse=0, one read outstanding, write request → gnt withheld until read rvalid; write granted at count 0, rvalid with err 0 next cycle.
- WriteResponse=1, write, read, write interleaved with responses in order, second response avm_response=2'b10 → rvalids in order; second response err=1, rdata=readdata.
- avm_waitrequest held high 5 cycles under a read → avm_read and address stable, no gnt; gnt on the cycle waitrequest drops.
- readdatavalid with nothing outstanding → protocol_err_o=1, no rvalid; stays 1 until rst_ni asserted, then 0.

Source files
------------

// File: rtl/avalon_ibex_translator_pipelined_if.sv
// Bus bundle between the ibex LSU data port, the translator and the Avalon-MM fabric.
// "master" is the translator's view (it masters Avalon); "slave" is the surrounding system.
interface avalon_ibex_translator_pipelined_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  localparam int BeWidth = DataWidth / 8;

  // ibex LSU side
  logic                 data_req_i;
  logic                 data_we_i;
  logic [BeWidth-1:0]   data_be_i;
  logic [AddrWidth-1:0] data_addr_i;
  logic [DataWidth-1:0] data_wdata_i;
  logic                 data_gnt_o;
  logic                 data_rvalid_o;
  logic [DataWidth-1:0] data_rdata_o;
  logic                 data_err_o;

  // Avalon-MM pipelined side
  logic [AddrWidth-1:0] avm_address;
  logic [BeWidth-1:0]   avm_byteenable;
  logic                 avm_read;
  logic                 avm_write;
  logic [DataWidth-1:0] avm_writedata;
  logic                 avm_waitrequest;
  logic                 avm_readdatavalid;
  logic [DataWidth-1:0] avm_readdata;
  logic [1:0]           avm_response;
  logic                 avm_writeresponsevalid;

  modport master (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response,
    input  avm_writeresponsevalid
  );

  modport slave (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdatavalid, avm_readdata, avm_response,
    output avm_writeresponsevalid
  );
endinterface

// File: rtl/avalon_ibex_translator_pipelined.sv
// ibex LSU req/gnt/rvalid to Avalon-MM pipelined master with in-order tracking of
// up to MaxOutstanding transactions and optional Avalon write responses.
module avalon_ibex_translator_pipelined #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  parameter int WordAddr       = 1,
  parameter int WriteResponse  = 0,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  avalon_ibex_translator_pipelined_if.master bus,
  output logic [CntW-1:0] outstanding_o,
  output logic            protocol_err_o
);
  localparam int BeWidth = DataWidth / 8;
  localparam int BeShift = (BeWidth > 1) ? $clog2(BeWidth) : 0;
  localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam bit WrRsp   = (WriteResponse != 0);

  logic [CntW-1:0]      count_reg, count_next;
  logic [PtrW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic                 fifo_reg [MaxOutstanding];
  logic                 wr_pend_reg;
  logic                 rvalid_reg;
  logic                 err_reg;
  logic [DataWidth-1:0] rdata_reg;
  logic                 protocol_err_reg;

  logic blocked, cmd_read, cmd_write, granted;
  logic push, pop, fifo_empty, head_is_write;
  logic rd_cpl, wr_cpl, stray, local_wr_done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Without write responses a write may only issue into a fully drained pipe, so
  // its locally generated rvalid can never overtake an outstanding read.
  always_comb begin
    fifo_empty    = (count_reg == '0);
    head_is_write = fifo_reg[rd_ptr_reg];
    blocked       = (count_reg == CntW'(MaxOutstanding)) |
                    (bus.data_we_i & ~WrRsp & (~fifo_empty | wr_pend_reg));
    cmd_read      = bus.data_req_i & ~bus.data_we_i & ~blocked;
    cmd_write     = bus.data_req_i &  bus.data_we_i & ~blocked;
    granted       = (cmd_read | cmd_write) & ~bus.avm_waitrequest;
    push          = granted & (~bus.data_we_i | WrRsp);
    local_wr_done = granted & bus.data_we_i & ~WrRsp;
    rd_cpl        = bus.avm_readdatavalid & ~fifo_empty & ~head_is_write;
    wr_cpl        = WrRsp & bus.avm_writeresponsevalid & ~fifo_empty & head_is_write;
    pop           = rd_cpl | wr_cpl;
    stray         = (bus.avm_readdatavalid & (fifo_empty | head_is_write)) |
                    (WrRsp & bus.avm_writeresponsevalid & (fifo_empty | ~head_is_write));
    count_next    = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CntW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CntW'(1);
    end
  end

  assign bus.avm_read       = cmd_read;
  assign bus.avm_write      = cmd_write;
  assign bus.avm_address    = (WordAddr != 0) ? (bus.data_addr_i >> BeShift) : bus.data_addr_i;
  assign bus.avm_byteenable = bus.data_be_i;
  assign bus.avm_writedata  = bus.data_wdata_i;
  assign bus.data_gnt_o     = granted;
  assign bus.data_rvalid_o  = rvalid_reg;
  assign bus.data_rdata_o   = rdata_reg;
  assign bus.data_err_o     = err_reg;
  assign outstanding_o      = count_reg;
  assign protocol_err_o     = protocol_err_reg;

  // One type bit per tracking slot: 1 marks a write awaiting its write response.
  for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_fifo
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fifo_reg[gi] <= 1'b0;
      end else if (push && (wr_ptr_reg == PtrW'(gi))) begin
        fifo_reg[gi] <= bus.data_we_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg        <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      wr_pend_reg      <= 1'b0;
      rvalid_reg       <= 1'b0;
      err_reg          <= 1'b0;
      rdata_reg        <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      count_reg        <= count_next;
      wr_pend_reg      <= local_wr_done;
      rvalid_reg       <= pop | local_wr_done;
      protocol_err_reg <= protocol_err_reg | stray;
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        err_reg    <= (bus.avm_response != 2'b00);
        rdata_reg  <= rd_cpl ? bus.avm_readdata : '0;
      end else if (local_wr_done) begin
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end
    end
  end
endmodule
